// File: rtl/noc_tag_sequencer.sv
// Runtime-configurable (row, col) tag sequencer for the PE-array NoC controller.
// Walks a num_rows x num_cols grid in row-fast or column-fast order and issues
// one tag per accepted enable until `total` tags have been consumed.
// All state updates on the falling clock edge.
module noc_tag_sequencer #(
    parameter int unsigned ROW_TAG_WIDTH = 4,
    parameter int unsigned COL_TAG_WIDTH = 4,
    parameter int unsigned COUNT_WIDTH   = 12
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     enable,
    input  logic                     mode,
    input  logic [ROW_TAG_WIDTH:0]   num_rows,
    input  logic [COL_TAG_WIDTH:0]   num_cols,
    input  logic [COUNT_WIDTH-1:0]   total,
    output logic                     busy,
    output logic                     valid,
    output logic [ROW_TAG_WIDTH-1:0] row_tag,
    output logic [COL_TAG_WIDTH-1:0] col_tag,
    output logic                     last,
    output logic                     wrap,
    output logic                     done,
    output logic                     cfg_err
);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    localparam logic [ROW_TAG_WIDTH:0] MaxRows = {1'b1, {ROW_TAG_WIDTH{1'b0}}};
    localparam logic [COL_TAG_WIDTH:0] MaxCols = {1'b1, {COL_TAG_WIDTH{1'b0}}};

    state_e                   state_q, state_d;
    logic [ROW_TAG_WIDTH-1:0] row_q, row_d;
    logic [COL_TAG_WIDTH-1:0] col_q, col_d;
    logic [COUNT_WIDTH-1:0]   count_q, count_d;
    logic [COUNT_WIDTH-1:0]   total_q, total_d;
    logic [ROW_TAG_WIDTH:0]   rows_q, rows_d;
    logic [COL_TAG_WIDTH:0]   cols_q, cols_d;
    logic                     mode_q, mode_d;
    logic                     wrap_q, wrap_d;
    logic                     cfg_err_q, cfg_err_d;

    logic row_at_end;
    logic col_at_end;
    logic is_last;

    // Position decodes against the latched (clamped) geometry.
    always_comb begin
        row_at_end = ({1'b0, row_q} == (rows_q - 1'b1));
        col_at_end = ({1'b0, col_q} == (cols_q - 1'b1));
        is_last    = (state_q == StRun) && (count_q == (total_q - 1'b1));
    end

    // Next-state logic: start/latch, advance, completion and abort.
    always_comb begin
        state_d   = state_q;
        row_d     = row_q;
        col_d     = col_q;
        count_d   = count_q;
        total_d   = total_q;
        rows_d    = rows_q;
        cols_d    = cols_q;
        mode_d    = mode_q;
        wrap_d    = 1'b0;
        cfg_err_d = cfg_err_q;

        unique case (state_q)
            StIdle: begin
                if (start && !abort) begin
                    if ((total != '0) && (num_rows != '0) && (num_cols != '0)) begin
                        mode_d    = mode;
                        rows_d    = (num_rows > MaxRows) ? MaxRows : num_rows;
                        cols_d    = (num_cols > MaxCols) ? MaxCols : num_cols;
                        total_d   = total;
                        row_d     = '0;
                        col_d     = '0;
                        count_d   = '0;
                        cfg_err_d = 1'b0;
                        state_d   = StRun;
                    end else begin
                        cfg_err_d = 1'b1;
                        state_d   = StDone;
                    end
                end
            end

            StRun: begin
                if (abort) begin
                    row_d   = '0;
                    col_d   = '0;
                    count_d = '0;
                    state_d = StIdle;
                end else if (enable) begin
                    if (is_last) begin
                        row_d   = '0;
                        col_d   = '0;
                        count_d = '0;
                        state_d = StDone;
                    end else begin
                        count_d = count_q + 1'b1;
                        if (!mode_q) begin
                            // Row-fast: row is the inner dimension.
                            if (row_at_end) begin
                                row_d = '0;
                                if (col_at_end) begin
                                    col_d  = '0;
                                    wrap_d = 1'b1;
                                end else begin
                                    col_d = col_q + 1'b1;
                                end
                            end else begin
                                row_d = row_q + 1'b1;
                            end
                        end else begin
                            // Column-fast: col is the inner dimension.
                            if (col_at_end) begin
                                col_d = '0;
                                if (row_at_end) begin
                                    row_d  = '0;
                                    wrap_d = 1'b1;
                                end else begin
                                    row_d = row_q + 1'b1;
                                end
                            end else begin
                                col_d = col_q + 1'b1;
                            end
                        end
                    end
                end
            end

            StDone: begin
                row_d   = '0;
                col_d   = '0;
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers, falling-edge clocked with asynchronous active-low reset.
    always_ff @(negedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= StIdle;
            row_q     <= '0;
            col_q     <= '0;
            count_q   <= '0;
            total_q   <= '0;
            rows_q    <= '0;
            cols_q    <= '0;
            mode_q    <= 1'b0;
            wrap_q    <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            row_q     <= row_d;
            col_q     <= col_d;
            count_q   <= count_d;
            total_q   <= total_d;
            rows_q    <= rows_d;
            cols_q    <= cols_d;
            mode_q    <= mode_d;
            wrap_q    <= wrap_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    // Output decode from registered state.
    always_comb begin
        busy    = (state_q == StRun);
        valid   = (state_q == StRun);
        done    = (state_q == StDone);
        row_tag = row_q;
        col_tag = col_q;
        last    = is_last;
        wrap    = wrap_q;
        cfg_err = cfg_err_q;
    end

endmodule

// File: tb/tb_noc_tag_sequencer.sv
// Directed bench for noc_tag_sequencer: traversal orders, wrap, stall,
// degenerate start, abort and asynchronous reset mid-run.
module tb_noc_tag_sequencer;

    localparam int RW = 4;
    localparam int CW = 4;
    localparam int NW = 12;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          enable = 1'b0;
    logic          mode = 1'b0;
    logic [RW:0]   num_rows = '0;
    logic [CW:0]   num_cols = '0;
    logic [NW-1:0] total = '0;
    logic          busy, valid, last, wrap, done, cfg_err;
    logic [RW-1:0] row_tag;
    logic [CW-1:0] col_tag;

    int checks = 0;
    int errors = 0;

    noc_tag_sequencer #(
        .ROW_TAG_WIDTH(RW),
        .COL_TAG_WIDTH(CW),
        .COUNT_WIDTH  (NW)
    ) dut (
        .clk     (clk),
        .reset_n (reset_n),
        .start   (start),
        .abort   (abort),
        .enable  (enable),
        .mode    (mode),
        .num_rows(num_rows),
        .num_cols(num_cols),
        .total   (total),
        .busy    (busy),
        .valid   (valid),
        .row_tag (row_tag),
        .col_tag (col_tag),
        .last    (last),
        .wrap    (wrap),
        .done    (done),
        .cfg_err (cfg_err)
    );

    always #5 clk = ~clk;

    // DUT updates on negedge; inputs driven and outputs sampled just after posedge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        #3;
        checks++;
        if ({busy, valid, last, wrap, done, cfg_err} !== 6'b0) begin
            errors++;
            $display("FAIL reset_flags: got %b expected 000000",
                     {busy, valid, last, wrap, done, cfg_err});
        end
        checks++;
        if (row_tag !== 4'd0 || col_tag !== 4'd0) begin
            errors++;
            $display("FAIL reset_tags: got (%0d,%0d) expected (0,0)", row_tag, col_tag);
        end
        step();
        reset_n = 1'b1;
        step();
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle: got busy=%b done=%b expected 0 0", busy, done);
        end
    endtask

    task automatic test_mode0();
        int er[6] = '{0, 1, 2, 0, 1, 2};
        int ec[6] = '{0, 0, 0, 1, 1, 1};
        mode = 1'b0; num_rows = 5'd3; num_cols = 5'd2; total = 12'd6;
        enable = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (valid !== 1'b1 || row_tag !== RW'(er[i]) || col_tag !== CW'(ec[i])) begin
                errors++;
                $display("FAIL mode0_tag[%0d]: got (%0d,%0d) valid=%b expected (%0d,%0d) valid=1",
                         i, row_tag, col_tag, valid, er[i], ec[i]);
            end
            checks++;
            if (last !== (i == 5) || wrap !== 1'b0 || done !== 1'b0) begin
                errors++;
                $display("FAIL mode0_flags[%0d]: got last=%b wrap=%b done=%b expected last=%b wrap=0 done=0",
                         i, last, wrap, done, (i == 5));
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0 || row_tag !== 4'd0 || col_tag !== 4'd0) begin
            errors++;
            $display("FAIL mode0_done: got done=%b valid=%b tag=(%0d,%0d) expected done=1 valid=0 (0,0)",
                     done, valid, row_tag, col_tag);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL mode0_idle: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_mode1();
        int er[6] = '{0, 0, 0, 1, 1, 1};
        int ec[6] = '{0, 1, 2, 0, 1, 2};
        mode = 1'b1; num_rows = 5'd2; num_cols = 5'd3; total = 12'd6;
        enable = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        // Config changes mid-run must be ignored.
        num_rows = 5'd1; num_cols = 5'd1; mode = 1'b0;
        for (int i = 0; i < 6; i++) begin
            checks++;
            if (valid !== 1'b1 || row_tag !== RW'(er[i]) || col_tag !== CW'(ec[i]) ||
                last !== (i == 5) || wrap !== 1'b0) begin
                errors++;
                $display("FAIL mode1_tag[%0d]: got (%0d,%0d) v=%b last=%b wrap=%b expected (%0d,%0d) v=1 last=%b wrap=0",
                         i, row_tag, col_tag, valid, last, wrap, er[i], ec[i], (i == 5));
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL mode1_done: got done=%b valid=%b expected 1 0", done, valid);
        end
        step();
    endtask

    task automatic test_wrap();
        int er[5] = '{0, 1, 0, 1, 0};
        int ec[5] = '{0, 0, 1, 1, 0};
        mode = 1'b0; num_rows = 5'd2; num_cols = 5'd2; total = 12'd5;
        enable = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (valid !== 1'b1 || row_tag !== RW'(er[i]) || col_tag !== CW'(ec[i]) ||
                wrap !== (i == 4) || last !== (i == 4)) begin
                errors++;
                $display("FAIL wrap_tag[%0d]: got (%0d,%0d) v=%b wrap=%b last=%b expected (%0d,%0d) v=1 wrap=%b last=%b",
                         i, row_tag, col_tag, valid, wrap, last, er[i], ec[i], (i == 4), (i == 4));
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || wrap !== 1'b0) begin
            errors++;
            $display("FAIL wrap_done: got done=%b wrap=%b expected 1 0", done, wrap);
        end
        step();
    endtask

    task automatic test_stall();
        int consumed = 0;
        int stalls = 0;
        bit seen_done = 1'b0;
        mode = 1'b0; num_rows = 5'd4; num_cols = 5'd1; total = 12'd4;
        enable = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 0; cyc < 20 && !seen_done; cyc++) begin
            if (done === 1'b1) begin
                seen_done = 1'b1;
            end else begin
                checks++;
                if (valid !== 1'b1 || row_tag !== RW'(consumed) || col_tag !== 4'd0 ||
                    last !== (consumed == 3)) begin
                    errors++;
                    $display("FAIL stall_tag[%0d]: got (%0d,%0d) v=%b last=%b expected (%0d,0) v=1 last=%b",
                             cyc, row_tag, col_tag, valid, last, consumed, (consumed == 3));
                end
                if (consumed == 2 && stalls < 3) begin
                    enable = 1'b0;
                    stalls++;
                end else begin
                    enable = 1'b1;
                    consumed++;
                end
                step();
            end
        end
        checks++;
        if (!seen_done || consumed != 4) begin
            errors++;
            $display("FAIL stall_count: got done_seen=%b consumed=%0d expected 1 4",
                     seen_done, consumed);
        end
        enable = 1'b1;
        step();
    endtask

    task automatic test_degenerate();
        mode = 1'b0; num_rows = 5'd2; num_cols = 5'd2; total = 12'd0;
        enable = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (done !== 1'b1 || cfg_err !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL degen_pulse: got done=%b cfg_err=%b valid=%b expected 1 1 0",
                     done, cfg_err, valid);
        end
        step();
        checks++;
        if (done !== 1'b0 || cfg_err !== 1'b1 || valid !== 1'b0) begin
            errors++;
            $display("FAIL degen_sticky: got done=%b cfg_err=%b valid=%b expected 0 1 0",
                     done, cfg_err, valid);
        end
        num_rows = 5'd1; num_cols = 5'd1; total = 12'd1; start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (valid !== 1'b1 || cfg_err !== 1'b0 || last !== 1'b1) begin
            errors++;
            $display("FAIL degen_clear: got valid=%b cfg_err=%b last=%b expected 1 0 1",
                     valid, cfg_err, last);
        end
        step();
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL degen_good_done: got done=%b expected 1", done);
        end
        step();
    endtask

    task automatic test_abort();
        mode = 1'b0; num_rows = 5'd4; num_cols = 5'd4; total = 12'd8;
        enable = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step(); step();
        checks++;
        if (row_tag !== 4'd3 || col_tag !== 4'd0 || valid !== 1'b1) begin
            errors++;
            $display("FAIL abort_pre: got (%0d,%0d) v=%b expected (3,0) v=1", row_tag, col_tag, valid);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
        checks++;
        if (busy !== 1'b0 || valid !== 1'b0 || done !== 1'b0 ||
            row_tag !== 4'd0 || col_tag !== 4'd0) begin
            errors++;
            $display("FAIL abort_idle: got busy=%b valid=%b done=%b (%0d,%0d) expected 0 0 0 (0,0)",
                     busy, valid, done, row_tag, col_tag);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_nodone: got done=%b busy=%b expected 0 0", done, busy);
        end
    endtask

    task automatic test_reset_midrun();
        mode = 1'b0; num_rows = 5'd3; num_cols = 5'd3; total = 12'd9;
        enable = 1'b1; start = 1'b1;
        step();
        start = 1'b0;
        step(); step();
        checks++;
        if (row_tag !== 4'd2 || valid !== 1'b1) begin
            errors++;
            $display("FAIL rst_pre: got row=%0d v=%b expected 2 1", row_tag, valid);
        end
        reset_n = 1'b0;
        #1;
        checks++;
        if ({busy, valid, last, wrap, done, cfg_err} !== 6'b0 ||
            row_tag !== 4'd0 || col_tag !== 4'd0) begin
            errors++;
            $display("FAIL rst_async: got flags=%b (%0d,%0d) expected 000000 (0,0)",
                     {busy, valid, last, wrap, done, cfg_err}, row_tag, col_tag);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_hold: got done=%b busy=%b expected 0 0", done, busy);
        end
        reset_n = 1'b1;
        step();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (valid !== 1'b1 || row_tag !== 4'd0 || col_tag !== 4'd0) begin
            errors++;
            $display("FAIL rst_restart: got (%0d,%0d) v=%b expected (0,0) v=1", row_tag, col_tag, valid);
        end
        abort = 1'b1;
        step();
        abort = 1'b0;
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode1();
        test_wrap();
        test_stall();
        test_degenerate();
        test_abort();
        test_reset_midrun();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
